// File: rtl/score_scan.sv
// Scoreboard frame sequencer: latches two scores, splits them into
// tens/units digits, then raster-scans four glyph slots into the glyph memory.
module score_scan #(
  parameter int GLYPH_W  = 32,
  parameter int GLYPH_H  = 32,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic       clk_sch,
  input  logic       rst_sch,
  input  logic       frame_start,
  input  logic [6:0] score_a,
  input  logic [6:0] score_b,
  input  logic       px_ready,
  output logic       px_valid,
  output logic [3:0] digit_out,
  output logic [4:0] row,
  output logic [4:0] col,
  output logic [1:0] slot,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    SCAN,
    DONE
  } state_t;

  localparam logic [4:0] COL_MAX = 5'(GLYPH_W - 1);
  localparam logic [4:0] ROW_MAX = 5'(GLYPH_H - 1);
  localparam logic [6:0] SAT     = 7'd99;

  state_t     state;
  logic [6:0] rem_a;
  logic [6:0] rem_b;
  logic [3:0] tens_a;
  logic [3:0] tens_b;

  logic       a_big;
  logic       b_big;
  logic       col_last;
  logic       slot_last;
  logic       row_last;
  logic [1:0] nslot;
  logic [3:0] digs [4];

  always_comb begin
    a_big     = rem_a >= 7'd10;
    b_big     = rem_b >= 7'd10;
    col_last  = col == COL_MAX;
    slot_last = slot == 2'd3;
    row_last  = row == ROW_MAX;
    nslot     = col_last ? slot + 2'd1 : slot;
    // a leading zero in a tens slot can be shown as a blank glyph
    digs[0] = (BLANK_LZ && tens_a == 4'd0) ? 4'hF : tens_a;
    digs[1] = rem_a[3:0];
    digs[2] = (BLANK_LZ && tens_b == 4'd0) ? 4'hF : tens_b;
    digs[3] = rem_b[3:0];
  end

  always_ff @(posedge clk_sch or negedge rst_sch) begin
    if (!rst_sch) begin
      state      <= IDLE;
      px_valid   <= 1'b0;
      digit_out  <= 4'hF;
      row        <= '0;
      col        <= '0;
      slot       <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      rem_a      <= '0;
      rem_b      <= '0;
      tens_a     <= '0;
      tens_b     <= '0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (frame_start) begin
            rem_a  <= (score_a > SAT) ? SAT : score_a;
            rem_b  <= (score_b > SAT) ? SAT : score_b;
            tens_a <= '0;
            tens_b <= '0;
            busy   <= 1'b1;
            state  <= CONV;
          end
        end
        CONV: begin
          if (a_big) begin
            rem_a  <= rem_a - 7'd10;
            tens_a <= tens_a + 4'd1;
          end
          if (b_big) begin
            rem_b  <= rem_b - 7'd10;
            tens_b <= tens_b + 4'd1;
          end
          if (!a_big && !b_big) begin
            state     <= SCAN;
            px_valid  <= 1'b1;
            row       <= '0;
            col       <= '0;
            slot      <= '0;
            digit_out <= digs[0];
          end
        end
        SCAN: begin
          if (px_ready) begin
            if (row_last && slot_last && col_last) begin
              px_valid   <= 1'b0;
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              col       <= col_last ? 5'd0 : col + 5'd1;
              digit_out <= digs[nslot];
              if (col_last) begin
                slot <= slot + 2'd1;
                if (slot_last) row <= row + 5'd1;
              end
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_scan.sv
// Scoreboard bench for score_scan: expected frames are queued at
// frame_start and every accepted beat is checked against the queue head.
module tb_score_scan;

  localparam int W    = 32;
  localparam int H    = 32;
  localparam int BEATS = W * H * 4;

  typedef struct {
    logic [15:0] dig;
    logic [15:0] dig0;
    int          conv;
    bit          lat;
  } frm_t;

  logic       clk = 1'b0;
  logic       rst_sch = 1'b0;
  logic       frame_start = 1'b0;
  logic [6:0] score_a = '0;
  logic [6:0] score_b = '0;
  logic       px_ready = 1'b1;

  logic       px_valid, busy, frame_done;
  logic [3:0] digit_out;
  logic [4:0] row, col;
  logic [1:0] slot;

  logic       v0, busy0, done0;
  logic [3:0] digit0;
  logic [4:0] row0, col0;
  logic [1:0] slot0;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   rnd = 1'b0;
  frm_t q[$];

  score_scan #(.GLYPH_W(W), .GLYPH_H(H), .BLANK_LZ(1'b1)) dut (
    .clk_sch(clk), .rst_sch(rst_sch), .frame_start(frame_start),
    .score_a(score_a), .score_b(score_b), .px_ready(px_ready),
    .px_valid(px_valid), .digit_out(digit_out), .row(row), .col(col),
    .slot(slot), .busy(busy), .frame_done(frame_done)
  );

  score_scan #(.GLYPH_W(W), .GLYPH_H(H), .BLANK_LZ(1'b0)) dut0 (
    .clk_sch(clk), .rst_sch(rst_sch), .frame_start(frame_start),
    .score_a(score_a), .score_b(score_b), .px_ready(px_ready),
    .px_valid(v0), .digit_out(digit0), .row(row0), .col(col0),
    .slot(slot0), .busy(busy0), .frame_done(done0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    px_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic frm_t mk(input int sa, input int sb, input bit lat);
    frm_t r;
    int a, b, ta, tb, ua, ub;
    a  = (sa > 99) ? 99 : sa;
    b  = (sb > 99) ? 99 : sb;
    ta = a / 10;
    ua = a % 10;
    tb = b / 10;
    ub = b % 10;
    r.dig  = {4'(ub), 4'(tb == 0 ? 15 : tb), 4'(ua), 4'(ta == 0 ? 15 : ta)};
    r.dig0 = {4'(ub), 4'(tb), 4'(ua), 4'(ta)};
    r.conv = ((ta > tb) ? ta : tb) + 1;
    r.lat  = lat;
    return r;
  endfunction

  // monitor
  int          idx = 0;
  int          conv_cnt = 0;
  int          first_cyc = 0;
  bit          prev_v = 1'b0;
  bit          held_v = 1'b0;
  logic [17:0] held;

  always @(negedge clk) begin
    if (!rst_sch) begin
      q.delete();
      idx      = 0;
      conv_cnt = 0;
      prev_v   = 1'b0;
      held_v   = 1'b0;
    end else begin
      if (held_v)
        chk("stall_hold", {14'd0, px_valid, row, slot, col, digit_out},
            {14'd0, held});
      held_v = px_valid && !px_ready;
      held   = {px_valid, row, slot, col, digit_out};
      if (busy && !px_valid && !frame_done) conv_cnt++;
      if (px_valid && !prev_v) begin
        first_cyc = cyc;
        if (q.size() != 0) chk("conv_cycles", conv_cnt, q[0].conv);
        conv_cnt = 0;
      end
      prev_v = px_valid;
      if (px_valid && px_ready) begin
        if (q.size() == 0) begin
          chk("beat_no_frame", 1, 0);
        end else begin
          int s;
          s = (idx / W) % 4;
          chk("beat", {row, slot, col, digit_out},
              {5'(idx / (4 * W)), 2'(s), 5'(idx % W), q[0].dig[s*4+:4]});
          chk("beat_lz0", {v0, busy0, row0, slot0, col0, digit0},
              {2'b11, row, slot, col, q[0].dig0[s*4+:4]});
          idx++;
        end
      end
      if (frame_done) begin
        if (q.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          chk("done_beats", idx, BEATS);
          chk("lz0_done", done0, 1);
          if (q[0].lat) chk("done_lat", cyc - first_cyc, BEATS);
          void'(q.pop_front());
          idx = 0;
        end
      end
    end
  end

  task automatic start(input int sa, input int sb, input bit lat);
    @(posedge clk);
    #1;
    score_a     = 7'(sa);
    score_b     = 7'(sb);
    frame_start = 1'b1;
    q.push_back(mk(sa, sb, lat));
    @(posedge clk);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (q.size() != 0 && n < 30000) begin
      @(posedge clk);
      n++;
    end
    chk("frame_timeout", q.size(), 0);
    #1;
    chk("idle_busy", {busy, px_valid}, 2'b00);
  endtask

  task automatic chk_rst();
    chk("rst_valid", px_valid, 0);
    chk("rst_digit", digit_out, 4'hF);
    chk("rst_pos", {row, slot, col}, 0);
    chk("rst_flags", {busy, frame_done}, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_rst();
    rst_sch = 1'b1;

    rnd = 1'b0;
    start(7, 42, 1'b1);
    wait_empty();

    start(0, 99, 1'b1);
    wait_empty();

    rnd = 1'b1;
    start(120, 5, 1'b0);
    wait_empty();

    // frame_start while scanning must not disturb the frame in flight
    start(13, 64, 1'b0);
    repeat (200) @(posedge clk);
    #1;
    score_a     = 7'd88;
    score_b     = 7'd3;
    frame_start = 1'b1;
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    score_a     = 7'd1;
    wait_empty();
    start(88, 3, 1'b0);
    wait_empty();

    // abort mid-scan
    rnd = 1'b0;
    start(31, 77, 1'b0);
    begin
      int n = 0;
      while (row != 5'd5 && n < 5000) begin
        @(posedge clk);
        n++;
      end
      chk("row5_reached", row, 5);
    end
    #1;
    rst_sch = 1'b0;
    #1;
    chk_rst();
    repeat (3) @(posedge clk);
    #1;
    rst_sch = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk_rst();
    rnd = 1'b1;
    start(55, 9, 1'b0);
    wait_empty();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
